// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package regfile_pkg;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wb_req_t;

  typedef enum logic {
    EXU_FIRST = 1'b0,
    LSU_FIRST = 1'b1
  } rr_e;
endpackage

// File: rtl/regfile_wb_arbiter_wb_slot.sv
// One-entry writeback holding slot: accepts when empty, empties on pop or clear.
module wb_slot
  import regfile_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    clear,
  input  logic    in_valid,
  input  wb_req_t in_req,
  output logic    in_ready,
  input  logic    pop,
  output logic    full,
  output wb_req_t entry
);
  logic    full_q, full_d;
  wb_req_t entry_q, entry_d;

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    full_d  = full_q;
    entry_d = entry_q;
    if (clear || pop) begin
      full_d = 1'b0;
    end else if (in_valid && !full_q) begin
      full_d  = 1'b1;
      entry_d = in_req;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) full_q <= 1'b0;
    else        full_q <= full_d;
  end

  // NOTE: the payload is not reset; it is only ever observed while full_q is set.
  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

  assign in_ready = !full_q;
  assign full     = full_q;
  assign entry    = entry_q;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbitration of EXU/LSU writebacks onto the single regfile write
// port, plus the per-register busy scoreboard used for decode RAW stalls.
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            exu_valid,
  output logic            exu_ready,
  input  logic [AW-1:0]   exu_rd_addr,
  input  logic [XLEN-1:0] exu_rd_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [AW-1:0]   lsu_rd_addr,
  input  logic [XLEN-1:0] lsu_rd_data,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd_addr,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            rf_write_en,
  output logic [AW-1:0]   rf_rd_addr,
  output logic [XLEN-1:0] rf_rd
);
  wb_req_t exu_req, lsu_req, exu_entry, lsu_entry, granted;
  logic    exu_full, lsu_full, grant_exu, grant_lsu, wr_en;
  rr_e     rr_q, rr_d;
  logic [NREG-1:1] busy_q, busy_d;
  logic [NREG-1:0] busy_vec, busy_nxt;

  assign exu_req = '{addr: exu_rd_addr, data: exu_rd_data};
  assign lsu_req = '{addr: lsu_rd_addr, data: lsu_rd_data};

  wb_slot u_exu_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (flush),
    .in_valid (exu_valid),
    .in_req   (exu_req),
    .in_ready (exu_ready),
    .pop      (grant_exu),
    .full     (exu_full),
    .entry    (exu_entry)
  );

  wb_slot u_lsu_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (flush),
    .in_valid (lsu_valid),
    .in_req   (lsu_req),
    .in_ready (lsu_ready),
    .pop      (grant_lsu),
    .full     (lsu_full),
    .entry    (lsu_entry)
  );

  always_comb begin
    grant_exu = 1'b0;
    grant_lsu = 1'b0;
    if (exu_full && lsu_full) begin
      if (rr_q == EXU_FIRST) grant_exu = 1'b1;
      else                   grant_lsu = 1'b1;
    end else if (exu_full) begin
      grant_exu = 1'b1;
    end else if (lsu_full) begin
      grant_lsu = 1'b1;
    end
  end

  // A granted x0 write is still consumed, it just never reaches the port.
  assign granted     = grant_lsu ? lsu_entry : exu_entry;
  assign wr_en       = rst_n && !flush && (grant_exu || grant_lsu) && (granted.addr != '0);
  assign rf_write_en = wr_en;
  assign rf_rd_addr  = wr_en ? granted.addr : '0;
  assign rf_rd       = wr_en ? granted.data : '0;

  always_comb begin
    rr_d = rr_q;
    if (!flush && exu_full && lsu_full) rr_d = grant_exu ? LSU_FIRST : EXU_FIRST;
  end

  assign busy_vec = {busy_q, 1'b0};
  assign rs1_busy = busy_vec[rs1_addr];
  assign rs2_busy = busy_vec[rs2_addr];

  // Clear first, then set, so an issue and a retire to the same register leave it busy.
  always_comb begin
    busy_nxt = busy_vec;
    if (wr_en) busy_nxt[rf_rd_addr] = 1'b0;
    if (iss_en && iss_rd_addr != '0) busy_nxt[iss_rd_addr] = 1'b1;
    if (flush) busy_nxt = '0;
    busy_d = busy_nxt[NREG-1:1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q   <= EXU_FIRST;
      busy_q <= '0;
    end else begin
      rr_q   <= rr_d;
      busy_q <= busy_d;
    end
  end

  // Decode must stall a WAW issue unless the older write retires this same cycle.
  a_no_waw_issue: assert property (@(posedge clk) disable iff (!rst_n)
    !(iss_en && !flush && iss_rd_addr != '0 && busy_vec[iss_rd_addr] &&
      !(wr_en && rf_rd_addr == iss_rd_addr)));
endmodule
